// File: rtl/gray_pupil_mask.sv
// Pupil-candidate mask: binarize grey stream against per-frame threshold, clean with 3x3 erosion.
// Latency: output for pixel k one clock after pixel k+LINE_W+1 is accepted; LINE_W+1 flush outputs end the frame.
// No backpressure: 1 pixel/clock, iDVAL gaps in RUN reappear as oDVAL gaps; build option GRAY_PUPIL_EROSION_EN.
module gray_pupil_mask #(
   parameter int LINE_W  = 640,
   parameter int FRAME_H = 480
) (
   input  logic                         iCLK,
   input  logic                         iRST,
   input  logic                         iFVAL,
   input  logic                         iDVAL,
   input  logic [9:0]                   iDATA,
   input  logic [9:0]                   iTHRESH,
   output logic                         oDVAL,
   output logic                         oMASK,
   output logic [9:0]                   oDATA,
   output logic [$clog2(LINE_W)-1:0]    oX,
   output logic [$clog2(FRAME_H)-1:0]   oY,
   output logic                         oEOF
);

   localparam int XW = $clog2(LINE_W);
   localparam int YW = $clog2(FRAME_H);
   localparam logic [XW-1:0] X_LAST = XW'(LINE_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(FRAME_H - 1);
   localparam logic [XW-1:0] X_ONE  = XW'(1);
   localparam logic [YW-1:0] Y_ONE  = YW'(1);

   typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

   state_t          state;
   state_t          stateNxt;

   logic            fvalD;
   logic [9:0]      thresh;

   // input-side position (line-buffer address) and output-side centre position
   logic [XW-1:0]   inX;
   logic [YW-1:0]   inY;
   logic [XW-1:0]   cX;
   logic [YW-1:0]   cY;

   // per-cycle control decoded by the FSM
   logic            start;
   logic            shiftEn;
   logic            emitEn;
   logic            zeroFill;
   logic            eofNxt;

   // storage: mask line buffers, grey line buffer and its one-pixel delay
   logic            lb1 [LINE_W];
   logic [9:0]      gBuf [LINE_W];
   logic [9:0]      gDly;

   logic            bIn;
   logic [9:0]      dIn;
   logic            lb1Rd;
   logic [9:0]      gRd;
   logic            maskNxt;

   // flush cycles push a synthetic zero pixel through the same pipe
   assign bIn   = zeroFill ? 1'b0 : (iDATA < thresh);
   assign dIn   = zeroFill ? 10'd0 : iDATA;
   assign lb1Rd = lb1[inX];
   assign gRd   = gBuf[inX];

`ifdef GRAY_PUPIL_EROSION_EN
   // rows of the 3x3 window, bit 0 is the newest column
   logic            lb2 [LINE_W];
   logic            lb2Rd;
   logic [2:0]      w0;
   logic [2:0]      w1;
   logic [2:0]      w2;
   logic [2:0]      nw0;
   logic [2:0]      nw1;
   logic [2:0]      nw2;
   logic            onBorder;

   assign lb2Rd    = lb2[inX];
   assign nw0      = {w0[1:0], lb2Rd};
   assign nw1      = {w1[1:0], lb1Rd};
   assign nw2      = {w2[1:0], bIn};
   // every out-of-frame neighbour lands on a border centre, so forcing borders covers it
   assign onBorder = (cX == '0) || (cX == X_LAST) || (cY == '0) || (cY == Y_LAST);
   assign maskNxt  = (&{nw0, nw1, nw2}) & ~onBorder;
`else
   // only one row of delay plus one column register is needed to align the raw bit
   logic            midD;

   assign maskNxt  = midD;
`endif

   // state register
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) state <= IDLE;
      else      state <= stateNxt;
   end

   // next state and per-cycle pipeline controls
   always_comb begin
      stateNxt = state;
      start    = 1'b0;
      shiftEn  = 1'b0;
      emitEn   = 1'b0;
      zeroFill = 1'b0;
      eofNxt   = 1'b0;
      case (state)
         IDLE: begin
            if (iFVAL && !fvalD) begin
               start    = 1'b1;
               stateNxt = FILL;
            end
         end
         FILL: begin
            if (!iFVAL) begin
               stateNxt = IDLE;
            end else if (iDVAL) begin
               shiftEn = 1'b1;
               // index LINE_W is the first pixel of row 1
               if (inX == '0 && inY == Y_ONE) stateNxt = RUN;
            end
         end
         RUN: begin
            if (!iFVAL) begin
               stateNxt = IDLE;
            end else if (iDVAL) begin
               shiftEn = 1'b1;
               emitEn  = 1'b1;
               if (inX == X_LAST && inY == Y_LAST) stateNxt = FLUSH;
            end
         end
         FLUSH: begin
            shiftEn  = 1'b1;
            emitEn   = 1'b1;
            zeroFill = 1'b1;
            if (cX == X_LAST && cY == Y_LAST) begin
               eofNxt   = 1'b1;
               stateNxt = IDLE;
            end
         end
         default: stateNxt = IDLE;
      endcase
   end

   // frame-valid edge history and per-frame threshold latch
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         fvalD  <= 1'b0;
         thresh <= 10'd0;
      end else begin
         fvalD <= iFVAL;
         if (start) thresh <= iTHRESH;
      end
   end

   // input position; row stops at the last line so it never leaves the frame
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         inX <= '0;
         inY <= '0;
      end else if (start) begin
         inX <= '0;
         inY <= '0;
      end else if (shiftEn) begin
         if (inX == X_LAST) begin
            inX <= '0;
            if (inY != Y_LAST) inY <= inY + Y_ONE;
         end else begin
            inX <= inX + X_ONE;
         end
      end
   end

   // centre position of the next output
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         cX <= '0;
         cY <= '0;
      end else if (start) begin
         cX <= '0;
         cY <= '0;
      end else if (emitEn) begin
         if (cX == X_LAST) begin
            cX <= '0;
            if (cY != Y_LAST) cY <= cY + Y_ONE;
         end else begin
            cX <= cX + X_ONE;
         end
      end
   end

   // line buffers: contents are don't-care across frames, so no reset
   always_ff @(posedge iCLK) begin
      if (shiftEn) begin
         lb1[inX]  <= bIn;
         gBuf[inX] <= dIn;
`ifdef GRAY_PUPIL_EROSION_EN
         lb2[inX]  <= lb1Rd;
`endif
      end
   end

   // window columns and grey delay advance once per accepted (or synthetic) pixel
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         gDly <= 10'd0;
`ifdef GRAY_PUPIL_EROSION_EN
         w0   <= '0;
         w1   <= '0;
         w2   <= '0;
`else
         midD <= 1'b0;
`endif
      end else if (shiftEn) begin
         gDly <= gRd;
`ifdef GRAY_PUPIL_EROSION_EN
         w0   <= nw0;
         w1   <= nw1;
         w2   <= nw2;
`else
         midD <= lb1Rd;
`endif
      end
   end

   // registered outputs; payload holds between valid cycles
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         oDVAL <= 1'b0;
         oMASK <= 1'b0;
         oDATA <= 10'd0;
         oX    <= '0;
         oY    <= '0;
         oEOF  <= 1'b0;
      end else begin
         oDVAL <= emitEn;
         oEOF  <= eofNxt;
         if (emitEn) begin
            oMASK <= maskNxt;
            oDATA <= gDly;
            oX    <= cX;
            oY    <= cY;
         end
      end
   end

endmodule

// File: tb/tb_gray_pupil_mask.sv
// Bench for gray_pupil_mask on a 4x3 frame: scoreboard of expected outputs including arrival cycle.
// Expected mask comes from a 2D frame model (erosion or raw, following GRAY_PUPIL_EROSION_EN).
// Covers reset, dark/ramp frames, gapped input, strict compare, abort and mid-frame reset.
module tb_gray_pupil_mask;

   localparam int W = 4;
   localparam int H = 3;
   localparam int N = W * H;

   logic       iCLK;
   logic       iRST;
   logic       iFVAL;
   logic       iDVAL;
   logic [9:0] iDATA;
   logic [9:0] iTHRESH;
   logic       oDVAL;
   logic       oMASK;
   logic [9:0] oDATA;
   logic [1:0] oX;
   logic [1:0] oY;
   logic       oEOF;

   gray_pupil_mask #(.LINE_W(W), .FRAME_H(H)) dut (
      .iCLK    (iCLK),
      .iRST    (iRST),
      .iFVAL   (iFVAL),
      .iDVAL   (iDVAL),
      .iDATA   (iDATA),
      .iTHRESH (iTHRESH),
      .oDVAL   (oDVAL),
      .oMASK   (oMASK),
      .oDATA   (oDATA),
      .oX      (oX),
      .oY      (oY),
      .oEOF    (oEOF)
   );

   typedef struct {
      int data;
      int mask;
      int x;
      int y;
      int eof;
      int cyc;
   } exp_t;

   exp_t expQ[$];
   exp_t e;
   int   img [N];
   bit   bArr [N];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   outCnt = 0;
   int   eofCnt = 0;

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   always @(posedge iCLK) cyc <= cyc + 1;

   task automatic checkVal(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // reference mask for centre k from the binarized frame
   function automatic int expMask(input int k);
      int x;
      int y;
      x = k % W;
      y = k / W;
`ifdef GRAY_PUPIL_EROSION_EN
      if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return 0;
      for (int dy = -1; dy <= 1; dy++)
         for (int dx = -1; dx <= 1; dx++)
            if (!bArr[(y + dy) * W + x + dx]) return 0;
      return 1;
`else
      if (x < 0) return 0;
      return bArr[k] ? 1 : 0;
`endif
   endfunction

   task automatic pushExp(input int k, input int c, input int eof);
      exp_t t;
      t.data = img[k];
      t.mask = expMask(k);
      t.x    = k % W;
      t.y    = k / W;
      t.eof  = eof;
      t.cyc  = c;
      expQ.push_back(t);
   endtask

   // monitor: sample away from the active edge, pop and compare
   always @(negedge iCLK) begin
      if (!iRST) begin
         if (oEOF && !oDVAL) checkVal("eof_without_dval", 1, 0);
         if (oDVAL) begin
            outCnt++;
            if (oEOF) eofCnt++;
            if (expQ.size() == 0) begin
               checkVal("unexpected_dval", 1, 0);
            end else begin
               e = expQ.pop_front();
               checkVal("data", int'(oDATA), e.data);
               checkVal("mask", int'(oMASK), e.mask);
               checkVal("x", int'(oX), e.x);
               checkVal("y", int'(oY), e.y);
               checkVal("eof", int'(oEOF), e.eof);
               checkVal("cycle", cyc, e.cyc);
            end
         end
      end
   end

   // drive one frame; stopAt < N aborts (or resets when doReset) after stopAt pixels
   task automatic runFrame(input int thr, input int base, input int step,
                           input bit gap, input int stopAt, input bit doReset);
      int a;
      int expCnt;
      for (int n = 0; n < N; n++) begin
         img[n]  = (base + step * n) & 1023;
         bArr[n] = (img[n] < thr);
      end
      outCnt  = 0;
      eofCnt  = 0;
      iTHRESH = thr[9:0];
      iFVAL   = 1'b1;
      iDVAL   = 1'b0;
      @(posedge iCLK); #1;
      for (int n = 0; n < N; n++) begin
         if (n == stopAt) break;
         if (gap && n > 0) begin
            iDVAL = 1'b0;
            @(posedge iCLK); #1;
         end
         iDVAL = 1'b1;
         iDATA = img[n][9:0];
         @(posedge iCLK); #1;
         a = cyc;
         if (n >= W + 1) pushExp(n - W - 1, a, 0);
         if (n == N - 1)
            for (int j = 0; j <= W; j++) pushExp(N - W - 1 + j, a + 1 + j, (j == W) ? 1 : 0);
      end
      iDVAL = 1'b0;
      iDATA = 10'd0;
      if (doReset) begin
         iRST = 1'b1;
         #1;
         checkVal("rst_mid_dval", int'(oDVAL), 0);
         checkVal("rst_mid_mask", int'(oMASK), 0);
         checkVal("rst_mid_data", int'(oDATA), 0);
         checkVal("rst_mid_x", int'(oX), 0);
         checkVal("rst_mid_y", int'(oY), 0);
         checkVal("rst_mid_eof", int'(oEOF), 0);
         expQ.delete();
         iFVAL = 1'b0;
         @(posedge iCLK); #1;
         iRST = 1'b0;
      end else begin
         iFVAL = 1'b0;
      end
      for (int t = 0; t < 40 && expQ.size() > 0; t++) @(posedge iCLK);
      checkVal("drain_timeout", expQ.size(), 0);
      repeat (W + 4) @(posedge iCLK);
      #1;
      if (!doReset) begin
         expCnt = (stopAt >= N) ? N : ((stopAt > W + 1) ? stopAt - W - 1 : 0);
         checkVal("out_count", outCnt, expCnt);
         checkVal("eof_count", eofCnt, (stopAt >= N) ? 1 : 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      iRST    = 1'b1;
      iFVAL   = 1'b0;
      iDVAL   = 1'b0;
      iDATA   = 10'd0;
      iTHRESH = 10'd0;
      repeat (3) @(posedge iCLK);
      #1;
      checkVal("rst_dval", int'(oDVAL), 0);
      checkVal("rst_mask", int'(oMASK), 0);
      checkVal("rst_data", int'(oDATA), 0);
      checkVal("rst_x", int'(oX), 0);
      checkVal("rst_y", int'(oY), 0);
      checkVal("rst_eof", int'(oEOF), 0);
      iRST = 1'b0;
      repeat (2) @(posedge iCLK);
      #1;

      runFrame(200, 100, 0, 1'b0, N, 1'b0);   // uniform dark
      runFrame(0,   0,   1, 1'b0, N, 1'b0);   // ramp, latency
      runFrame(0,   0,   1, 1'b1, N, 1'b0);   // ramp, gapped
      runFrame(200, 100, 0, 1'b0, 7, 1'b0);   // abort after 7 pixels
      runFrame(200, 100, 0, 1'b0, N, 1'b0);   // full frame after abort
      runFrame(100, 100, 0, 1'b0, N, 1'b0);   // equality gives 0
      runFrame(6,   0,   1, 1'b1, N, 1'b0);   // mixed threshold, gapped
      runFrame(200, 0,   1, 1'b0, 8, 1'b1);   // reset mid-RUN
      runFrame(200, 100, 0, 1'b0, N, 1'b0);   // recovery frame

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
